// File: rtl/decode_issue_stage.sv
// LC-3b decode/issue stage: decodes the fetched word, checks the pending-write
// scoreboard, bypasses writeback data, and loads a single-entry ID/EX register.
module decode_issue_stage #(
   parameter int NUM_REGS = 8,
   parameter int WORD_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        if_valid,
   output logic                        if_ready,
   input  logic [WORD_W-1:0]           if_ir,
   input  logic [WORD_W-1:0]           if_pc,
   output logic [$clog2(NUM_REGS)-1:0] rf_src_a,
   output logic [$clog2(NUM_REGS)-1:0] rf_src_b,
   input  logic [WORD_W-1:0]           rf_reg_a,
   input  logic [WORD_W-1:0]           rf_reg_b,
   input  logic                        wb_valid,
   input  logic [$clog2(NUM_REGS)-1:0] wb_dest,
   input  logic [WORD_W-1:0]           wb_data,
   output logic                        ex_valid,
   input  logic                        ex_ready,
   output logic [WORD_W-1:0]           ex_ir,
   output logic [WORD_W-1:0]           ex_pc,
   output logic [WORD_W-1:0]           ex_op_a,
   output logic [WORD_W-1:0]           ex_op_b,
   output logic [$clog2(NUM_REGS)-1:0] ex_dest,
   output logic                        ex_writes
);
   localparam int RW = $clog2(NUM_REGS);

   typedef struct packed {
      logic [WORD_W-1:0] ir;
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] op_a;
      logic [WORD_W-1:0] op_b;
      logic [RW-1:0]     dest;
      logic              writes;
   } idex_t;

   idex_t               idex;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic [3:0]          op;
   logic                is_store;
   logic                use_a;
   logic                use_b;
   logic                writes;
   logic [RW-1:0]       dest;
   logic                hit_a;
   logic                hit_b;
   logic                hit_d;
   logic                stall;
   logic                issue;
   logic [WORD_W-1:0]   op_a;
   logic [WORD_W-1:0]   op_b;

   assign op       = if_ir[15:12];
   assign is_store = (op == 4'b0011) || (op == 4'b0111) || (op == 4'b1011);
   assign rf_src_a = if_ir[8:6];
   assign rf_src_b = is_store ? if_ir[11:9] : if_ir[2:0];

   always_comb begin
      use_a  = 1'b0;
      use_b  = 1'b0;
      writes = 1'b0;
      dest   = if_ir[11:9];
      case (op)
         4'b0001, 4'b0101: begin          // ADD, AND
            use_a  = 1'b1;
            use_b  = !if_ir[5];
            writes = 1'b1;
         end
         4'b1001, 4'b1101, 4'b0010, 4'b0110, 4'b1010: begin  // NOT, SHF, loads
            use_a  = 1'b1;
            writes = 1'b1;
         end
         4'b0011, 4'b0111, 4'b1011: begin // stores
            use_a = 1'b1;
            use_b = 1'b1;
         end
         4'b1100: use_a = 1'b1;           // JMP
         4'b1110: writes = 1'b1;          // LEA
         4'b0100: begin                   // JSR/JSRR link into R7
            use_a  = !if_ir[11];
            writes = 1'b1;
            dest   = RW'(7);
         end
         4'b1111: begin                   // TRAP links into R7
            writes = 1'b1;
            dest   = RW'(7);
         end
         default: ;
      endcase
   end

   // A writeback to a busy register in this same cycle resolves the hazard.
   assign hit_a = wb_valid && (wb_dest == rf_src_a);
   assign hit_b = wb_valid && (wb_dest == rf_src_b);
   assign hit_d = wb_valid && (wb_dest == dest);
   assign stall = (use_a && busy[rf_src_a] && !hit_a) ||
                  (use_b && busy[rf_src_b] && !hit_b) ||
                  (writes && busy[dest] && !hit_d);

   assign if_ready = !stall && !flush && (!ex_valid || ex_ready);
   assign issue    = if_valid && if_ready;
   assign op_a     = hit_a ? wb_data : rf_reg_a;
   assign op_b     = hit_b ? wb_data : rf_reg_b;

   // Clear-then-set ordering lets a same-index issue win over writeback.
   always_comb begin
      busy_nxt = busy;
      if (wb_valid) busy_nxt[wb_dest] = 1'b0;
      if (flush && ex_valid && idex.writes) busy_nxt[idex.dest] = 1'b0;
      if (issue && writes) busy_nxt[dest] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idex     <= '0;
         ex_valid <= 1'b0;
         busy     <= '0;
      end else begin
         busy <= busy_nxt;
         if (flush) begin
            ex_valid <= 1'b0;
         end else if (issue) begin
            ex_valid <= 1'b1;
            idex     <= '{ir: if_ir, pc: if_pc, op_a: op_a, op_b: op_b,
                          dest: dest, writes: writes};
         end else if (ex_ready) begin
            ex_valid <= 1'b0;
         end
      end
   end

   assign ex_ir     = idex.ir;
   assign ex_pc     = idex.pc;
   assign ex_op_a   = idex.op_a;
   assign ex_op_b   = idex.op_b;
   assign ex_dest   = idex.dest;
   assign ex_writes = idex.writes;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: expected ID/EX contents are queued at
// issue time and compared one cycle later; scoreboard state checked by value.
module tb_decode_issue_stage;
   logic        clk = 1'b0;
   logic        rst_n, flush, if_valid, if_ready;
   logic [15:0] if_ir, if_pc, rf_reg_a, rf_reg_b, wb_data;
   logic [2:0]  rf_src_a, rf_src_b, wb_dest, ex_dest;
   logic        wb_valid, ex_valid, ex_ready, ex_writes;
   logic [15:0] ex_ir, ex_pc, ex_op_a, ex_op_b;
   logic [15:0] regs [8];

   typedef struct {
      logic [15:0] ir, pc, a, b;
      logic [2:0]  dest;
      logic        wr;
   } ex_t;
   ex_t sb[$];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign rf_reg_a = regs[rf_src_a];
   assign rf_reg_b = regs[rf_src_b];

   decode_issue_stage #(.NUM_REGS(8), .WORD_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready), .if_ir(if_ir), .if_pc(if_pc),
      .rf_src_a(rf_src_a), .rf_src_b(rf_src_b), .rf_reg_a(rf_reg_a), .rf_reg_b(rf_reg_b),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ir(ex_ir), .ex_pc(ex_pc),
      .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_dest(ex_dest), .ex_writes(ex_writes)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_busy(input logic [7:0] exp);
      chk("busy", {8'h00, dut.busy}, {8'h00, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for one cycle; if issue is expected, queue the
   // ID/EX contents it must produce and compare them after the edge.
   task automatic step(input logic [15:0] ir, input logic exp_ready,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] dest, input logic wr);
      ex_t e;
      if_valid = 1'b1;
      if_ir    = ir;
      if_pc    = ir + 16'h0100;
      #1;
      chk("if_ready", {15'd0, if_ready}, {15'd0, exp_ready});
      if (exp_ready) sb.push_back('{ir, ir + 16'h0100, a, b, dest, wr});
      tick();
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("ex_valid", {15'd0, ex_valid}, 16'd1);
         chk("ex_ir", ex_ir, e.ir);
         chk("ex_pc", ex_pc, e.pc);
         chk("ex_op_a", ex_op_a, e.a);
         chk("ex_op_b", ex_op_b, e.b);
         chk("ex_dest", {13'd0, ex_dest}, {13'd0, e.dest});
         chk("ex_writes", {15'd0, ex_writes}, {15'd0, e.wr});
      end
      if_valid = 1'b0;
   endtask

   task automatic set_wb(input logic v, input logic [2:0] d, input logic [15:0] data);
      wb_valid = v;
      wb_dest  = d;
      wb_data  = data;
   endtask

   task automatic chk_cleared();
      chk("rst ex_valid", {15'd0, ex_valid}, 16'd0);
      chk("rst ex_ir", ex_ir, 16'd0);
      chk("rst ex_pc", ex_pc, 16'd0);
      chk("rst ex_op_a", ex_op_a, 16'd0);
      chk("rst ex_op_b", ex_op_b, 16'd0);
      chk("rst ex_dest", {13'd0, ex_dest}, 16'd0);
      chk("rst ex_writes", {15'd0, ex_writes}, 16'd0);
      chk_busy(8'h00);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);
      regs[2] = 16'h0005;
      regs[3] = 16'h0007;
      regs[5] = 16'h0555;
      regs[6] = 16'h0666;
      rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; if_ir = '0; if_pc = '0;
      ex_ready = 1'b1;
      set_wb(1'b0, 3'd0, 16'h0);
      tick();
      tick();
      chk_cleared();
      rst_n = 1'b1;

      // ADD R1,R2,R3
      step(16'h1283, 1'b1, 16'h0005, 16'h0007, 3'd1, 1'b1);
      chk_busy(8'h02);

      // ADD R4,R1,#1 stalls on R1, then issues with the bypassed writeback value
      step(16'h1861, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
      chk("drain ex_valid", {15'd0, ex_valid}, 16'd0);
      set_wb(1'b1, 3'd1, 16'h00AB);
      step(16'h1861, 1'b1, 16'h00AB, 16'h00AB, 3'd4, 1'b1);
      set_wb(1'b0, 3'd0, 16'h0);
      chk_busy(8'h10);

      // Backpressure: AND R3,R2,#0 waits while execute is not ready
      ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(16'h56A0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
         chk("hold ex_valid", {15'd0, ex_valid}, 16'd1);
         chk("hold ex_ir", ex_ir, 16'h1861);
         chk("hold ex_op_a", ex_op_a, 16'h00AB);
      end
      ex_ready = 1'b1;
      step(16'h56A0, 1'b1, 16'h0005, 16'h1000, 3'd3, 1'b1);
      chk_busy(8'h18);

      // LEA R5 makes R5 pending; STW R5,R6,#0 stalls on its store-data source
      step(16'hEA00, 1'b1, 16'h1000, 16'h1000, 3'd5, 1'b1);
      chk_busy(8'h38);
      step(16'h7B80, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
      set_wb(1'b1, 3'd5, 16'h5555);
      step(16'h7B80, 1'b1, 16'h0666, 16'h5555, 3'd5, 1'b0);
      set_wb(1'b0, 3'd0, 16'h0);
      chk_busy(8'h18);

      // JSR links R7; TRAP hits WAW on R7 until it retires (set beats clear)
      step(16'h4800, 1'b1, 16'h1000, 16'h1000, 3'd7, 1'b1);
      chk_busy(8'h98);
      step(16'hF025, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
      set_wb(1'b1, 3'd7, 16'h7777);
      step(16'hF025, 1'b1, 16'h1000, 16'h0555, 3'd7, 1'b1);
      set_wb(1'b0, 3'd0, 16'h0);
      chk_busy(8'h98);

      // ADD R2,R0,R1 then flush it, with a concurrent writeback of R3
      step(16'h1401, 1'b1, 16'h1000, 16'h1001, 3'd2, 1'b1);
      chk_busy(8'h9C);
      flush = 1'b1;
      set_wb(1'b1, 3'd3, 16'h3333);
      step(16'h9DBF, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
      flush = 1'b0;
      set_wb(1'b0, 3'd0, 16'h0);
      chk("flush ex_valid", {15'd0, ex_valid}, 16'd0);
      chk("flush ex_ir", ex_ir, 16'h1401);
      chk_busy(8'h90);

      // Reset in the middle of a stall on R4
      step(16'h1321, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
      if_valid = 1'b1;
      rst_n = 1'b0;
      tick();
      chk_cleared();
      rst_n = 1'b1;
      if_valid = 1'b0;
      tick();
      chk("idle ex_valid", {15'd0, ex_valid}, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
